// File: rtl/aes_v1_arb.sv
// rtl/aes_v1_arb.sv - round-robin arbiter sharing one aes_v1 SBox/MixColumn unit among NREQ requesters
module aes_v1_arb #(
  parameter int NREQ       = 2,
  parameter int DECRYPT_EN = 1,
  localparam int GW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              g_clk,
  input  logic              g_reset,
  input  logic [NREQ-1:0]   rq_valid,
  output logic [NREQ-1:0]   rq_ready,
  input  logic [NREQ-1:0]   rq_dec,
  input  logic [NREQ-1:0]   rq_mix,
  input  logic [32*NREQ-1:0] rq_rs1,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [31:0]       rsp_rd,
  output logic              aes_valid,
  output logic              aes_dec,
  output logic              aes_mix,
  output logic [31:0]       aes_rs1,
  input  logic              aes_ready,
  input  logic [31:0]       aes_rd,
  output logic              busy,
  output logic [GW-1:0]     gnt_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q;
  logic [GW-1:0] ptr_q, ptr_d;
  logic [GW-1:0] gnt_id_q;
  logic          op_dec_q, op_mix_q;
  logic [31:0]   op_rs1_q;
  logic [31:0]   res_q;
  logic [GW-1:0] sel;
  logic          found;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    sel   = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int j = 0; j < NREQ; j++) begin
      idx = int'(ptr_q) + j;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && rq_valid[idx]) begin
        found = 1'b1;
        sel   = GW'(idx);
      end
    end
  end

  assign ptr_d = (gnt_id_q == GW'(NREQ - 1)) ? '0 : gnt_id_q + 1'b1;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_id_q <= '0;
      op_dec_q <= 1'b0;
      op_mix_q <= 1'b0;
      op_rs1_q <= '0;
      res_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            gnt_id_q <= sel;
            op_dec_q <= rq_dec[sel];
            op_mix_q <= rq_mix[sel];
            op_rs1_q <= rq_rs1[int'(sel)*32 +: 32];
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          // MixColumn completes combinationally in the issue cycle.
          if (aes_ready) begin
            res_q   <= aes_rd;
            state_q <= RESP;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (aes_ready) begin
            res_q   <= aes_rd;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready[gnt_id_q]) begin
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The accept pulse is combinational so it lands in the grant cycle; masked while reset is held.
  assign rq_ready  = (state_q == IDLE && found && !g_reset) ? (NREQ'(1) << sel) : '0;
  assign rsp_valid = (state_q == RESP) ? (NREQ'(1) << gnt_id_q) : '0;
  assign rsp_rd    = res_q;
  assign aes_valid = (state_q == ISSUE);
  assign aes_dec   = op_dec_q & (DECRYPT_EN != 0);
  assign aes_mix   = op_mix_q;
  assign aes_rs1   = op_rs1_q;
  assign busy      = (state_q != IDLE);
  assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_aes_v1_arb.sv
// tb/tb_aes_v1_arb.sv - directed bench for aes_v1_arb with a behavioural aes_v1 unit stub
module tb_aes_v1_arb;

  logic        clk, rst;
  logic [1:0]  rq_valid, rq_dec, rq_mix, rsp_ready;
  logic [63:0] rq_rs1;

  logic [1:0]  rq_ready_w  [2];
  logic [1:0]  rsp_valid_w [2];
  logic [31:0] rsp_rd_w    [2];
  logic        aes_valid_w [2];
  logic        aes_dec_w   [2];
  logic        aes_mix_w   [2];
  logic [31:0] aes_rs1_w   [2];
  logic        aes_ready_w [2];
  logic [31:0] aes_rd_w    [2];
  logic        busy_w      [2];
  logic        gnt_w       [2];
  logic        s_act       [2];
  logic [1:0]  s_cnt       [2];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Known unit results for the operand patterns used here.
  function automatic logic [31:0] unit_rd(input logic d, input logic m, input logic [31:0] x);
    logic [31:0] r;
    r = 32'hdeadbeef;
    if (!d && !m && x == 32'h00000000) r = 32'h63636363;
    if (!d && !m && x == 32'h63636363) r = 32'hfbfbfbfb;
    if ( d && !m && x == 32'h63636363) r = 32'h00000000;
    if (!d &&  m && x == 32'h455313db) r = 32'hbca14d8e;
    if ( d &&  m && x == 32'hbca14d8e) r = 32'h455313db;
    return r;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    // SubBytes stub: bytes B0..B3 in the four cycles after issue, ready on the last.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_act[k] <= 1'b0;
        s_cnt[k] <= 2'd0;
      end else if (aes_valid_w[k] && !aes_mix_w[k]) begin
        s_act[k] <= 1'b1;
        s_cnt[k] <= 2'd0;
      end else if (s_act[k]) begin
        if (s_cnt[k] == 2'd3) s_act[k] <= 1'b0;
        else                  s_cnt[k] <= s_cnt[k] + 2'd1;
      end
    end
    assign aes_ready_w[k] = (aes_valid_w[k] && aes_mix_w[k]) || (s_act[k] && s_cnt[k] == 2'd3);
    assign aes_rd_w[k]    = unit_rd(aes_dec_w[k], aes_mix_w[k], aes_rs1_w[k]);

    aes_v1_arb #(.NREQ(2), .DECRYPT_EN(k == 0 ? 1 : 0)) u_dut (
      .g_clk     (clk),
      .g_reset   (rst),
      .rq_valid  (rq_valid),
      .rq_ready  (rq_ready_w[k]),
      .rq_dec    (rq_dec),
      .rq_mix    (rq_mix),
      .rq_rs1    (rq_rs1),
      .rsp_valid (rsp_valid_w[k]),
      .rsp_ready (rsp_ready),
      .rsp_rd    (rsp_rd_w[k]),
      .aes_valid (aes_valid_w[k]),
      .aes_dec   (aes_dec_w[k]),
      .aes_mix   (aes_mix_w[k]),
      .aes_rs1   (aes_rs1_w[k]),
      .aes_ready (aes_ready_w[k]),
      .aes_rd    (aes_rd_w[k]),
      .busy      (busy_w[k]),
      .gnt_id    (gnt_w[k])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    int          who;
    logic        dec;
    logic        mix;
    logic [31:0] rs1;
    int          lat;
    logic [31:0] exp_rd;
    logic        chk2;
    logic [31:0] exp_rd2;
    int          hold;
  } vec_t;

  vec_t vecs[6];

  // Starts and ends one time unit after a rising edge.
  task automatic run_op(input vec_t v);
    int          nav, av_cyc;
    bit          got;
    logic [31:0] rd_seen;
    rq_valid         = 2'b00;
    rq_valid[v.who]  = 1'b1;
    rq_dec[v.who]    = v.dec;
    rq_mix[v.who]    = v.mix;
    rq_rs1[v.who*32 +: 32] = v.rs1;
    @(negedge clk);
    check("rq_ready_c0", 32'(rq_ready_w[0]), 32'(2'b01 << v.who));
    @(posedge clk); #1;
    rq_valid = 2'b00;
    nav = 0; av_cyc = -1; got = 0; rd_seen = '0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (aes_valid_w[0]) begin
        nav++;
        av_cyc = c;
        check("aes_dec", 32'(aes_dec_w[0]), 32'(v.dec));
        check("aes_dec_noenc", 32'(aes_dec_w[1]), 32'd0);
        check("aes_rs1", aes_rs1_w[0], v.rs1);
      end
      if (rsp_valid_w[0] != 2'b00) begin
        got = 1;
        check("rsp_latency", c, v.lat);
        check("rsp_valid_bit", 32'(rsp_valid_w[0]), 32'(2'b01 << v.who));
        check("rsp_rd", rsp_rd_w[0], v.exp_rd);
        if (v.chk2) check("rsp_rd_noenc", rsp_rd_w[1], v.exp_rd2);
        rd_seen = rsp_rd_w[0];
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!got) check("rsp_timeout", 32'd0, 32'd1);
    check("aes_valid_count", nav, 1);
    check("aes_valid_cycle", av_cyc, 1);
    if (got) begin
      for (int h = 0; h < v.hold; h++) begin
        @(posedge clk); #1;
        rq_valid = 2'b11;
        @(negedge clk);
        check("hold_rsp_valid", 32'(rsp_valid_w[0]), 32'(2'b01 << v.who));
        check("hold_rsp_rd", rsp_rd_w[0], rd_seen);
        check("hold_rq_ready", 32'(rq_ready_w[0]), 32'd0);
        check("hold_aes_valid", 32'(aes_valid_w[0]), 32'd0);
      end
      @(posedge clk); #1;
      rsp_ready[v.who] = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 2'b00;
      rq_valid  = 2'b00;
      @(negedge clk);
      check("idle_busy", 32'(busy_w[0]), 32'd0);
      check("idle_rsp_valid", 32'(rsp_valid_w[0]), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int          grants[$];
    int          nresp;
    logic [31:0] exp_r [2];

    vecs[0] = '{0, 1'b0, 1'b0, 32'h00000000, 6, 32'h63636363, 1'b1, 32'h63636363, 0};
    vecs[1] = '{1, 1'b1, 1'b0, 32'h63636363, 6, 32'h00000000, 1'b1, 32'hfbfbfbfb, 0};
    vecs[2] = '{0, 1'b0, 1'b1, 32'h455313db, 2, 32'hbca14d8e, 1'b1, 32'hbca14d8e, 0};
    vecs[3] = '{0, 1'b1, 1'b1, 32'hbca14d8e, 2, 32'h455313db, 1'b0, 32'h0,        0};
    vecs[4] = '{1, 1'b0, 1'b1, 32'h455313db, 2, 32'hbca14d8e, 1'b1, 32'hbca14d8e, 0};
    vecs[5] = '{1, 1'b0, 1'b0, 32'h00000000, 6, 32'h63636363, 1'b1, 32'h63636363, 10};

    rst = 1'b1;
    rq_valid = 2'b01; rq_dec = '0; rq_mix = '0; rq_rs1 = '0; rsp_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rq_ready", 32'(rq_ready_w[0]), 32'd0);
    check("rst_busy", 32'(busy_w[0]), 32'd0);
    check("rst_aes_valid", 32'(aes_valid_w[0]), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_w[0]), 32'd0);
    check("rst_rsp_rd", rsp_rd_w[0], 32'd0);
    check("rst_gnt", 32'(gnt_w[0]), 32'd0);
    @(posedge clk); #1;
    rq_valid = 2'b00;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_op(vecs[i]);

    // Both requesters pending with responses always taken: grants must alternate.
    exp_r[0] = 32'hbca14d8e;
    exp_r[1] = 32'h63636363;
    rq_mix = 2'b01; rq_dec = 2'b00;
    rq_rs1 = {32'h00000000, 32'h455313db};
    rq_valid = 2'b11; rsp_ready = 2'b11;
    nresp = 0;
    for (int c = 0; c < 60 && nresp < 4; c++) begin
      @(negedge clk);
      if (rq_ready_w[0] != 2'b00) grants.push_back(rq_ready_w[0] == 2'b10 ? 1 : 0);
      if (rsp_valid_w[0] != 2'b00) begin
        if (nresp < grants.size()) begin
          check("alt_rsp_bit", 32'(rsp_valid_w[0]), 32'(2'b01 << grants[nresp]));
          check("alt_rsp_rd", rsp_rd_w[0], exp_r[grants[nresp]]);
        end
        nresp++;
      end
      @(posedge clk); #1;
      if (nresp >= 4) rq_valid = 2'b00;
    end
    rq_valid = 2'b00; rsp_ready = 2'b00;
    check("alt_resp_count", nresp, 4);
    check("alt_grant_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) check("alt_grant_order", grants[i], i % 2);
    @(posedge clk); #1;

    // Reset while the unit is mid-SubBytes.
    rq_mix = 2'b00; rq_dec = 2'b00; rq_rs1 = {32'h63636363, 32'h0};
    rq_valid = 2'b10;
    @(posedge clk); #1;
    rq_valid = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    check("wait_busy", 32'(busy_w[0]), 32'd1);
    check("wait_gnt", 32'(gnt_w[0]), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy_w[0]), 32'd0);
    check("midrst_gnt", 32'(gnt_w[0]), 32'd0);
    check("midrst_aes_rs1", aes_rs1_w[0], 32'd0);
    check("midrst_aes_valid", 32'(aes_valid_w[0]), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid_w[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(vecs[0]);
    run_op(vecs[2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
